tile_edit_controller: RTL
=========================

// Module: tile_edit_controller
// PURPOSE
//  Converts each player's "edit" keypress into a validated one-cycle tile-index pulse (change1/change2)
//  for the map-holding stage directly downstream. Computes the faced tile, checks the map code there,
//  and enforces occupancy, same-tile conflict, win-freeze and per-player cooldown rules.
// PARAMETERS
//  MAP_W            20          tiles per row
//  MAP_H            15          tiles per column; map index = y*MAP_W + x, 0..MAP_W*MAP_H-1
//  COOLDOWN_CYCLES  12_500_000  cycles a player is locked out after an issued edit (0.25 s @ 50 MHz)
// PORTS
//  Clk          in   1       system clock; the single clock
//  Reset        in   1       synchronous, active-high reset
//  p1_x, p2_x   in   5       player tile column, 0..MAP_W-1
//  p1_y, p2_y   in   4       player tile row, 0..MAP_H-1
//  p1_dir,p2_dir in  2       facing: 0 up (y-1), 1 right (x+1), 2 down (y+1), 3 left (x-1)
//  p1_act,p2_act in  1       edit key level; only a 0->1 edge requests an edit
//  map          in   int[300] current tile codes from the downstream map stage
//  win1, win2   in   1       round-over flags
//  change1,change2 out int   tile index to toggle, valid for one cycle; 0 = no edit
//  deny1, deny2 out  1       one-cycle pulse: request rejected
//  ready1,ready2 out 1       player FSM in IDLE (accepting a new edge)
// BEHAVIOUR
//  Reset: change*=0, deny*=0, ready*=1, FSMs IDLE, cooldown counters 0, act_prev registers =1
//   (a key held through reset does not fire). Reset mid-operation aborts any pending edit silently.
//  Per-player FSM (two identical, independent instances):
//   IDLE: on act & ~act_prev & ~(win1|win2): latch target (x,y) from dir -> CHECK.
//   CHECK (1 cycle): deny if target off-grid (x-1 or y-1 underflow, x>=MAP_W, y>=MAP_H),
//    map[idx] not in {0,2,6} (1 border, 3/4 goals, 5 solid are uneditable),
//    idx == other player's current tile, or conflict (below). Deny -> pulse denyN, -> IDLE.
//    Else -> ISSUE.
//   ISSUE (1 cycle): changeN = idx -> COOLDOWN, counter loaded with COOLDOWN_CYCLES-1.
//   COOLDOWN: decrement each cycle; at 0 -> IDLE. Edges during COOLDOWN are discarded, not queued.
//  Latency: act edge sampled at cycle n -> CHECK n+1 -> change pulse registered, visible n+2.
//  Conflict: P1 has priority. P2 in CHECK with same idx as P1 in CHECK or ISSUE -> deny2.
//   P1 is never denied on P2's account. Different tiles in the same cycle: both issue.
//  Win freeze: while win1|win2, FSMs forced to IDLE at next edge, counters cleared,
//   change*=0, deny*=0; edges ignored until both flags clear.
//  Index arithmetic: idx = y*MAP_W + x in 9 bits unsigned, zero-extended to int on output;
//   idx 0 is a border tile, so 0 unambiguously means "none".
//  All outputs registered; map is sampled only in CHECK (no combinational path map->change).
//  act_prev updates every cycle in every state, so edge detection stays coherent after COOLDOWN.
// STRUCTURE
//  map_pkg: MAP_W, MAP_H, tile codes TILE_EMPTY=0, TILE_BORDER=1, TILE_BRICK=2, TILE_GOAL_A=3,
//   TILE_GOAL_B=4, TILE_SOLID=5, TILE_CRACKED=6; dir_t enum {DIR_UP,DIR_RIGHT,DIR_DOWN,DIR_LEFT};
//   edit_state_t enum {IDLE,CHECK,ISSUE,COOLDOWN}; function tile_idx(x,y).
//  Sub-module edit_port_fsm (one player: edge detect, target calc, FSM, cooldown counter),
//   instantiated twice; top holds map read mux, occupancy/conflict compare, win freeze.
// TESTING (bench COOLDOWN_CYCLES=8)
//  P1 (5,5) dir right, map[106]=0, act rises @n -> change1=106 at n+2 for 1 cycle, ready1=0 for 9.
//  P1 (1,1) dir up -> target (1,0) map[1]=1 -> deny1 pulse at n+2, change1 stays 0.
//  P1 (4,3) right, P2 (6,3) left, both act @n, map[65]=2 -> change1=65, deny2, change2=0.
//  P2 (18,13) dir right -> x=19 border -> deny2; dir down -> y=14 border -> deny2.
//  Act held high through Reset then kept high -> no pulse; re-press after COOLDOWN works, within ignored.
//  win1=1 during P1 COOLDOWN -> ready1=1 next cycle; act edges while win1=1 produce no change1/deny1.

Source files
------------

// File: rtl/tile_edit_controller_pkg.sv
// rtl/tile_edit_controller_pkg.sv - map geometry, tile codes, edit FSM types and index helpers
package tile_edit_controller_pkg;

  localparam int MAP_W = 20;
  localparam int MAP_H = 15;
  localparam int MAP_N = MAP_W * MAP_H;

  localparam int TILE_EMPTY   = 0;
  localparam int TILE_BORDER  = 1;
  localparam int TILE_BRICK   = 2;
  localparam int TILE_GOAL_A  = 3;
  localparam int TILE_GOAL_B  = 4;
  localparam int TILE_SOLID   = 5;
  localparam int TILE_CRACKED = 6;

  typedef enum logic [1:0] {DIR_UP, DIR_RIGHT, DIR_DOWN, DIR_LEFT} dir_t;

  typedef enum logic [1:0] {IDLE, CHECK, ISSUE, COOLDOWN} edit_state_t;

  // Row-major tile index; the largest on-grid value (299) fits in 9 bits.
  function automatic logic [8:0] tile_idx(input logic [4:0] x, input logic [3:0] y);
    tile_idx = 9'(y) * 9'(MAP_W) + 9'(x);
  endfunction

  // Only empty, brick and cracked tiles may be toggled by a player.
  function automatic logic tile_editable(input int code);
    tile_editable = (code == TILE_EMPTY) || (code == TILE_BRICK) || (code == TILE_CRACKED);
  endfunction

endpackage

// File: rtl/tile_edit_controller_if.sv
// rtl/tile_edit_controller_if.sv - player inputs, map view and edit outputs of the controller
interface tile_edit_controller_if;
  import tile_edit_controller_pkg::*;

  logic [4:0] p1_x, p2_x;
  logic [3:0] p1_y, p2_y;
  logic [1:0] p1_dir, p2_dir;
  logic       p1_act, p2_act;
  int         map [MAP_N];
  logic       win1, win2;
  int         change1, change2;
  logic       deny1, deny2;
  logic       ready1, ready2;

  modport master (
    output p1_x, p2_x, p1_y, p2_y, p1_dir, p2_dir, p1_act, p2_act, map, win1, win2,
    input  change1, change2, deny1, deny2, ready1, ready2
  );

  modport slave (
    input  p1_x, p2_x, p1_y, p2_y, p1_dir, p2_dir, p1_act, p2_act, map, win1, win2,
    output change1, change2, deny1, deny2, ready1, ready2
  );

endinterface

// File: rtl/tile_edit_controller_edit_port_fsm.sv
// rtl/tile_edit_controller_edit_port_fsm.sv - one player's edge detect, target latch, edit FSM and cooldown
module edit_port_fsm
  import tile_edit_controller_pkg::*;
#(
  parameter int COOLDOWN_CYCLES = 12_500_000,
  parameter bit YIELD           = 1'b0
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] x_i,
  input  logic [3:0] y_i,
  input  logic [1:0] dir_i,
  input  logic       act_i,
  input  logic       freeze_i,
  input  logic       reject_i,
  input  logic       other_claim_i,
  input  logic [8:0] other_tgt_i,
  output logic [8:0] tgt_o,
  output logic       claim_o,
  output int         change_o,
  output logic       deny_o,
  output logic       ready_o
);

  localparam int CNT_W = (COOLDOWN_CYCLES > 2) ? $clog2(COOLDOWN_CYCLES) : 1;

  edit_state_t state_q, state_d;
  logic        act_prev_q;
  logic [8:0]  tgt_q, tgt_d;
  logic        off_q, off_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  int          change_q, change_d;
  logic        deny_q, deny_d;
  logic        ready_q, ready_d;

  logic [5:0] tx;
  logic [4:0] ty;
  logic       off;
  logic       conflict;

  // Faced tile from position and direction; underflow wraps high and is caught by the bound test.
  always_comb begin
    tx  = {1'b0, x_i};
    ty  = {1'b0, y_i};
    off = 1'b0;
    unique case (dir_t'(dir_i))
      DIR_UP:    begin off = (y_i == 4'd0); ty = ty - 5'd1; end
      DIR_RIGHT: tx = tx + 6'd1;
      DIR_DOWN:  ty = ty + 5'd1;
      DIR_LEFT:  begin off = (x_i == 5'd0); tx = tx - 6'd1; end
      default:   ;
    endcase
    off = off | (tx >= 6'(MAP_W)) | (ty >= 5'(MAP_H));
  end

  // A yielding player loses any tile the other player is checking or issuing this cycle.
  assign conflict = YIELD & other_claim_i & (other_tgt_i == tgt_q);
  assign claim_o  = ((state_q == CHECK) & ~off_q) | (state_q == ISSUE);
  assign tgt_o    = tgt_q;

  // Next state; the ISSUE cycle counts as the first lockout cycle, so COOLDOWN leaves at count 1.
  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    off_d    = off_q;
    cnt_d    = cnt_q;
    change_d = 0;
    deny_d   = 1'b0;
    if (freeze_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (act_i && !act_prev_q) begin
            tgt_d   = tile_idx(tx[4:0], ty[3:0]);
            off_d   = off;
            state_d = CHECK;
          end
        end
        CHECK: begin
          if (off_q || reject_i || conflict) begin
            deny_d  = 1'b1;
            state_d = IDLE;
          end else begin
            change_d = {23'b0, tgt_q};
            state_d  = ISSUE;
          end
        end
        ISSUE: begin
          cnt_d   = CNT_W'(COOLDOWN_CYCLES - 1);
          state_d = COOLDOWN;
        end
        COOLDOWN: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q <= CNT_W'(1)) begin
            cnt_d   = '0;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    ready_d = (state_d == IDLE);
  end

  // State and registered outputs; act_prev resets high so a key held through reset never fires.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      act_prev_q <= 1'b1;
      tgt_q      <= '0;
      off_q      <= 1'b0;
      cnt_q      <= '0;
      change_q   <= 0;
      deny_q     <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      state_q    <= state_d;
      act_prev_q <= act_i;
      tgt_q      <= tgt_d;
      off_q      <= off_d;
      cnt_q      <= cnt_d;
      change_q   <= change_d;
      deny_q     <= deny_d;
      ready_q    <= ready_d;
    end
  end

  assign change_o = change_q;
  assign deny_o   = deny_q;
  assign ready_o  = ready_q;

endmodule

// File: rtl/tile_edit_controller.sv
// rtl/tile_edit_controller.sv - two-player tile edit validation with map lookup, occupancy and win freeze
module tile_edit_controller
  import tile_edit_controller_pkg::*;
#(
  parameter int COOLDOWN_CYCLES = 12_500_000
) (
  input logic               Clk,
  input logic               Reset,
  tile_edit_controller_if.slave edit_if
);

  logic       freeze;
  logic [8:0] p1_tgt, p2_tgt;
  logic [8:0] p1_tile, p2_tile;
  logic       p1_claim, p2_claim;
  logic       reject1, reject2;

  assign freeze  = edit_if.win1 | edit_if.win2;
  assign p1_tile = tile_idx(edit_if.p1_x, edit_if.p1_y);
  assign p2_tile = tile_idx(edit_if.p2_x, edit_if.p2_y);

  // Map code and occupancy verdicts; only consumed while the player sits in CHECK.
  always_comb begin
    reject1 = !tile_editable(edit_if.map[p1_tgt]) || (p1_tgt == p2_tile);
    reject2 = !tile_editable(edit_if.map[p2_tgt]) || (p2_tgt == p1_tile);
  end

  edit_port_fsm #(.COOLDOWN_CYCLES(COOLDOWN_CYCLES), .YIELD(1'b0)) u_p1 (
    .clk_i         (Clk),
    .rst_i         (Reset),
    .x_i           (edit_if.p1_x),
    .y_i           (edit_if.p1_y),
    .dir_i         (edit_if.p1_dir),
    .act_i         (edit_if.p1_act),
    .freeze_i      (freeze),
    .reject_i      (reject1),
    .other_claim_i (p2_claim),
    .other_tgt_i   (p2_tgt),
    .tgt_o         (p1_tgt),
    .claim_o       (p1_claim),
    .change_o      (edit_if.change1),
    .deny_o        (edit_if.deny1),
    .ready_o       (edit_if.ready1)
  );

  edit_port_fsm #(.COOLDOWN_CYCLES(COOLDOWN_CYCLES), .YIELD(1'b1)) u_p2 (
    .clk_i         (Clk),
    .rst_i         (Reset),
    .x_i           (edit_if.p2_x),
    .y_i           (edit_if.p2_y),
    .dir_i         (edit_if.p2_dir),
    .act_i         (edit_if.p2_act),
    .freeze_i      (freeze),
    .reject_i      (reject2),
    .other_claim_i (p1_claim),
    .other_tgt_i   (p1_tgt),
    .tgt_o         (p2_tgt),
    .claim_o       (p2_claim),
    .change_o      (edit_if.change2),
    .deny_o        (edit_if.deny2),
    .ready_o       (edit_if.ready2)
  );

endmodule
